counter_csr_port: RTL and testbench

//   CSR-side reader/writer for a bank of NUM_CNT 64-bit split (high/low) counters. Sits between the
//   CSR request/response channel and the counter instances in the parent; drives their write strobes,

---
 rtl/counter_csr_pkg.sv | 33 +++
 rtl/counter_csr_port_if.sv | 26 ++
 rtl/counter_csr_port.sv | 129 ++++++++++++
 tb/tb_counter_csr_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_csr_pkg.sv
// Shared types and address decode for the counter CSR port.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package counter_csr_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Index fields are carried at the widest supported size (31 counters + inhibit slot).
  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 half;
    logic                 is_inhibit;
    logic                 is_err;
  } addr_dec_t;

  // Slot num_cnt/low is the inhibit register; its high half and anything above are holes.
  function automatic addr_dec_t decode_addr(input logic [MAX_IDX_W-1:0] idx,
                                            input logic                 half,
                                            input logic [MAX_IDX_W-1:0] num_cnt);
    addr_dec_t d;
    d.idx        = idx;
    d.half       = half;
    d.is_inhibit = (idx == num_cnt) && (half == HALF_LO);
    d.is_err     = (idx > num_cnt) || ((idx == num_cnt) && (half == HALF_HI));
    return d;
  endfunction

endpackage

// File: rtl/counter_csr_port_if.sv
// CSR request/response channel between a CSR master and the counter port.
// Latency: wires only.
// Backpressure: valid/ready on both request and response.
interface counter_csr_port_if #(parameter int ADDR_W = 4);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/counter_csr_port.sv
// CSR reader/writer for a bank of 64-bit split counters with tear-free reads and increment inhibit.
// Latency: response registered one cycle after accept; write strobes combinational in the accept cycle.
// Backpressure: one outstanding transaction; req_ready low until the response handshakes.
module counter_csr_port
  import counter_csr_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int IDX_W   = $clog2(NUM_CNT + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  counter_csr_port_if.slave             csr,
  input  logic [NUM_CNT-1:0]            event_in,
  output logic [NUM_CNT-1:0]            cnt_incr_en,
  output logic [NUM_CNT-1:0]            cnt_high_we,
  output logic [NUM_CNT-1:0]            cnt_low_we,
  output logic [31:0]                   cnt_wdata,
  input  logic [NUM_CNT-1:0][31:0]      cnt_high_rdata,
  input  logic [NUM_CNT-1:0][31:0]      cnt_low_rdata
);

  localparam logic [0:0]           ST_IDLE   = 1'(IDLE);
  localparam logic [0:0]           ST_RESP   = 1'(RESP);
  localparam logic [MAX_IDX_W-1:0] NUM_CNT_L = MAX_IDX_W'(NUM_CNT);

  logic [0:0]         state;
  logic [NUM_CNT-1:0] inhibit;
  logic [31:0]        shadow [NUM_CNT];
  logic [NUM_CNT-1:0] shadow_valid;

  addr_dec_t          dec;
  logic               accept;
  logic               is_cnt;
  logic [NUM_CNT-1:0] sel;
  logic [31:0]        lo_live;
  logic [31:0]        hi_live;
  logic [31:0]        hi_shadow;
  logic               shadow_hit;
  logic [31:0]        rd_next;

  // No handshake can complete while reset is held, so no strobe fires and nothing is lost.
  assign csr.req_ready = (state == ST_IDLE) && !reset;
  assign accept        = csr.req_valid && csr.req_ready;

  assign cnt_wdata   = csr.req_wdata;
  assign cnt_incr_en = event_in & ~inhibit;
  assign cnt_high_we = (accept && csr.req_we && dec.half == HALF_HI) ? sel : '0;
  assign cnt_low_we  = (accept && csr.req_we && dec.half == HALF_LO) ? sel : '0;

  // Decode the address, pick the addressed counter and form the read data for this request.
  always_comb begin
    dec        = decode_addr(MAX_IDX_W'(csr.req_addr[IDX_W:1]), csr.req_addr[0], NUM_CNT_L);
    is_cnt     = !dec.is_err && !dec.is_inhibit;
    sel        = '0;
    lo_live    = '0;
    hi_live    = '0;
    hi_shadow  = '0;
    shadow_hit = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (is_cnt && dec.idx == MAX_IDX_W'(i)) begin
        sel[i]     = 1'b1;
        lo_live    = cnt_low_rdata[i];
        hi_live    = cnt_high_rdata[i];
        hi_shadow  = shadow[i];
        shadow_hit = shadow_valid[i];
      end
    end
    rd_next = '0;
    if (!csr.req_we && !dec.is_err) begin
      if (dec.is_inhibit)
        rd_next = 32'(inhibit);
      else if (dec.half == HALF_LO)
        rd_next = lo_live;
      else
        rd_next = shadow_hit ? hi_shadow : hi_live;
    end
  end

  // Transaction FSM, registered response and inhibit register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      csr.rsp_valid <= 1'b0;
      csr.rsp_rdata <= '0;
      csr.rsp_err   <= 1'b0;
      inhibit       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_RESP;
            csr.rsp_valid <= 1'b1;
            csr.rsp_rdata <= rd_next;
            csr.rsp_err   <= dec.is_err;
          end
        end
        default: begin
          if (csr.rsp_valid && csr.rsp_ready) begin
            state         <= ST_IDLE;
            csr.rsp_valid <= 1'b0;
          end
        end
      endcase
      if (accept && csr.req_we && dec.is_inhibit)
        inhibit <= csr.req_wdata[NUM_CNT-1:0];
    end
  end

  // Snapshot validity: a low read arms it, a high read consumes it, any write to the counter discards it.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (accept && sel[i])
          shadow_valid[i] <= !csr.req_we && (dec.half == HALF_LO);
      end
    end
  end

  // Snapshot data: capture the high word on the same edge the low word is returned.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (accept && sel[i] && !csr.req_we && dec.half == HALF_LO)
        shadow[i] <= cnt_high_rdata[i];
    end
  end

endmodule

// File: tb/tb_counter_csr_port.sv
// Directed bench for counter_csr_port: counters are modelled as directly driven live high/low words.
module tb_counter_csr_port;

  localparam int NUM_CNT = 4;
  localparam int IDX_W   = 3;

  logic                     clock;
  logic                     reset;
  logic [NUM_CNT-1:0]       event_in;
  logic [NUM_CNT-1:0]       cnt_incr_en;
  logic [NUM_CNT-1:0]       cnt_high_we;
  logic [NUM_CNT-1:0]       cnt_low_we;
  logic [31:0]              cnt_wdata;
  logic [NUM_CNT-1:0][31:0] cnt_high_rdata;
  logic [NUM_CNT-1:0][31:0] cnt_low_rdata;

  int errors = 0;
  int checks = 0;

  counter_csr_port_if #(.ADDR_W(IDX_W + 1)) csr_if ();

  counter_csr_port #(.NUM_CNT(NUM_CNT), .IDX_W(IDX_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .csr            (csr_if),
    .event_in       (event_in),
    .cnt_incr_en    (cnt_incr_en),
    .cnt_high_we    (cnt_high_we),
    .cnt_low_we     (cnt_low_we),
    .cnt_wdata      (cnt_wdata),
    .cnt_high_rdata (cnt_high_rdata),
    .cnt_low_rdata  (cnt_low_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns at posedge+1. Captures strobes in the accept cycle and one cycle later.
  task automatic csr_xfer(input  logic               we,
                          input  logic [IDX_W:0]     addr,
                          input  logic [31:0]        wdata,
                          output logic [31:0]        rdata,
                          output logic               err,
                          output logic [NUM_CNT-1:0] hwe,
                          output logic [NUM_CNT-1:0] lwe,
                          output logic [NUM_CNT-1:0] hwe2,
                          output logic [NUM_CNT-1:0] lwe2,
                          output logic [31:0]        wd_seen);
    int n;
    csr_if.req_valid = 1'b1;
    csr_if.req_we    = we;
    csr_if.req_addr  = addr;
    csr_if.req_wdata = wdata;
    #1;
    hwe     = cnt_high_we;
    lwe     = cnt_low_we;
    wd_seen = cnt_wdata;
    @(posedge clock); #1;
    hwe2 = cnt_high_we;
    lwe2 = cnt_low_we;
    csr_if.req_valid = 1'b0;
    n = 0;
    while (!csr_if.rsp_valid && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 10) check("rsp_timeout", 64'd1, 64'd0);
    rdata = csr_if.rsp_rdata;
    err   = csr_if.rsp_err;
    csr_if.rsp_ready = 1'b1;
    @(posedge clock); #1;
    csr_if.rsp_ready = 1'b0;
  endtask

  logic [31:0]        rd, wd;
  logic               er;
  logic [NUM_CNT-1:0] h1, l1, h2, l2;

  initial begin
    reset            = 1'b1;
    event_in         = '0;
    cnt_high_rdata   = '0;
    cnt_low_rdata    = '0;
    csr_if.req_valid = 1'b0;
    csr_if.req_we    = 1'b0;
    csr_if.req_addr  = '0;
    csr_if.req_wdata = '0;
    csr_if.rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    event_in = 4'hF;
    #1;
    check("rst_rsp_valid", csr_if.rsp_valid, 0);
    check("rst_rsp_err",   csr_if.rsp_err,   0);
    check("rst_rsp_rdata", csr_if.rsp_rdata, 0);
    check("rst_req_ready", csr_if.req_ready, 1);
    check("rst_incr_en",   cnt_incr_en,      4'hF);
    @(posedge clock); #1;

    // Tear-free read across a carry: low snapshot, then live words move to 1:0.
    event_in          = 4'h1;
    cnt_high_rdata[0] = 32'h0000_0000;
    cnt_low_rdata[0]  = 32'hFFFF_FFFF;
    csr_xfer(1'b0, 4'b0000, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("c0_lo_rdata", rd, 32'hFFFF_FFFF);
    check("c0_lo_err",   er, 0);
    check("c0_lo_we",    {h1, l1}, 0);
    cnt_high_rdata[0] = 32'h0000_0001;
    cnt_low_rdata[0]  = 32'h0000_0000;
    csr_xfer(1'b0, 4'b0001, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("c0_hi_shadow", rd, 32'h0000_0000);
    csr_xfer(1'b0, 4'b0001, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("c0_hi_live_after_consume", rd, 32'h0000_0001);

    // High read with no prior low read returns the live word.
    cnt_high_rdata[2] = 32'h0000_00AB;
    csr_xfer(1'b0, 4'b0101, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("c2_hi_rdata", rd, 32'h0000_00AB);
    check("c2_hi_err",   er, 0);

    // Counter write strobes for exactly one cycle.
    csr_xfer(1'b1, 4'b0011, 32'h1234, rd, er, h1, l1, h2, l2, wd);
    check("c1_wr_hwe",   h1, 4'b0010);
    check("c1_wr_lwe",   l1, 4'b0000);
    check("c1_wr_wdata", wd, 32'h1234);
    check("c1_wr_hwe2",  h2, 4'b0000);
    check("c1_wr_rdata", rd, 0);
    check("c1_wr_err",   er, 0);
    csr_xfer(1'b1, 4'b0010, 32'h5678, rd, er, h1, l1, h2, l2, wd);
    check("c1_wr_lo_lwe", l1, 4'b0010);
    check("c1_wr_lo_hwe", h1, 4'b0000);

    // A write discards a pending snapshot.
    cnt_high_rdata[1] = 32'h55;
    csr_xfer(1'b0, 4'b0010, 32'h0, rd, er, h1, l1, h2, l2, wd);
    cnt_high_rdata[1] = 32'h77;
    csr_xfer(1'b1, 4'b0011, 32'h77, rd, er, h1, l1, h2, l2, wd);
    csr_xfer(1'b0, 4'b0011, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("c1_hi_after_wr_live", rd, 32'h77);

    // Inhibit register.
    event_in = 4'hF;
    csr_xfer(1'b1, 4'b1000, 32'h2, rd, er, h1, l1, h2, l2, wd);
    check("inh_wr_strobes", {h1, l1}, 0);
    check("inh_wr_err",     er, 0);
    check("inh_incr_en",    cnt_incr_en, 4'hD);
    csr_xfer(1'b0, 4'b1000, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("inh_rd", rd, 32'h2);

    // Response held for 5 cycles of backpressure; live word changes must not leak through.
    cnt_low_rdata[3] = 32'hCAFE;
    csr_if.req_valid = 1'b1;
    csr_if.req_we    = 1'b0;
    csr_if.req_addr  = 4'b0110;
    @(posedge clock); #1;
    csr_if.req_valid = 1'b0;
    cnt_low_rdata[3] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", csr_if.rsp_valid, 1);
      check("bp_rsp_rdata", csr_if.rsp_rdata, 32'hCAFE);
      check("bp_req_ready", csr_if.req_ready, 0);
      @(posedge clock); #1;
    end
    csr_if.rsp_ready = 1'b1;
    @(posedge clock); #1;
    csr_if.rsp_ready = 1'b0;
    check("bp_done_rsp_valid", csr_if.rsp_valid, 0);
    check("bp_done_req_ready", csr_if.req_ready, 1);

    // Bad addresses: no strobes, no inhibit change.
    csr_xfer(1'b1, 4'b1010, 32'hFFFF, rd, er, h1, l1, h2, l2, wd);
    check("err_wr_err",     er, 1);
    check("err_wr_rdata",   rd, 0);
    check("err_wr_strobes", {h1, l1}, 0);
    check("err_wr_incr_en", cnt_incr_en, 4'hD);
    csr_xfer(1'b0, 4'b1001, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("err_inh_hi_err",   er, 1);
    check("err_inh_hi_rdata", rd, 0);
    csr_xfer(1'b0, 4'b1111, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("err_idx7_err", er, 1);

    // Back-to-back low reads: last snapshot wins.
    cnt_high_rdata[0] = 32'h10;
    csr_xfer(1'b0, 4'b0000, 32'h0, rd, er, h1, l1, h2, l2, wd);
    cnt_high_rdata[0] = 32'h20;
    csr_xfer(1'b0, 4'b0000, 32'h0, rd, er, h1, l1, h2, l2, wd);
    cnt_high_rdata[0] = 32'h30;
    csr_xfer(1'b0, 4'b0001, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("b2b_hi_last_snap", rd, 32'h20);

    // Reset while a response is pending.
    csr_if.req_valid = 1'b1;
    csr_if.req_we    = 1'b0;
    csr_if.req_addr  = 4'b0000;
    @(posedge clock); #1;
    csr_if.req_valid = 1'b0;
    check("rr_rsp_pending", csr_if.rsp_valid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rr_rsp_valid", csr_if.rsp_valid, 0);
    check("rr_incr_en",   cnt_incr_en, 4'hF);
    csr_if.req_valid = 1'b1;
    csr_if.req_we    = 1'b1;
    csr_if.req_addr  = 4'b0011;
    #1;
    check("rr_no_strobe", {cnt_high_we, cnt_low_we}, 0);
    csr_if.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rr_req_ready", csr_if.req_ready, 1);
    @(posedge clock); #1;
    cnt_high_rdata[0] = 32'h40;
    csr_xfer(1'b0, 4'b0001, 32'h0, rd, er, h1, l1, h2, l2, wd);
    check("rr_shadow_cleared", rd, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
